// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between IFU (read) and LSU (read/write), one access in flight.
// Zero-wait latency is 3 cycles (grant, issue, response); req_ready is only offered in IDLE, no response backpressure.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [ADDR_W-1:0]     ifu_addr,
    output logic                  ifu_rsp_valid,
    output logic [DATA_W-1:0]     ifu_rdata,
    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic [ADDR_W-1:0]     lsu_addr,
    input  logic                  lsu_wen,
    input  logic [DATA_W-1:0]     lsu_wdata,
    input  logic [DATA_W/8-1:0]   lsu_wmask,
    output logic                  lsu_rsp_valid,
    output logic [DATA_W-1:0]     lsu_rdata,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_wen,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wmask,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    state_t                state;
    state_t                state_nxt;
    logic                  owner;
    logic                  last_owner;
    logic [ADDR_W-1:0]     addr_q;
    logic                  wen_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [DATA_W/8-1:0]   wmask_q;
    logic                  grant_ifu;
    logic                  grant_lsu;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        grant_ifu     = 1'b0;
        grant_lsu     = 1'b0;
        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;
        mem_req_valid = 1'b0;
        ifu_rsp_valid = 1'b0;
        lsu_rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                // No grant while reset is held, so nothing is accepted into a clearing datapath.
                if (!rst) begin
                    grant_ifu = ifu_req_valid && (!lsu_req_valid || last_owner == OWN_LSU);
                    grant_lsu = lsu_req_valid && !grant_ifu;
                end
                ifu_req_ready = grant_ifu;
                lsu_req_ready = grant_lsu;
                if (grant_ifu || grant_lsu) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (mem_rsp_valid) begin
                    ifu_rsp_valid = (owner == OWN_IFU);
                    lsu_rsp_valid = (owner == OWN_LSU);
                    state_nxt     = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner      <= OWN_IFU;
            last_owner <= OWN_LSU;
            addr_q     <= '0;
            wen_q      <= 1'b0;
            wdata_q    <= '0;
            wmask_q    <= '0;
        end else if (grant_ifu) begin
            owner      <= OWN_IFU;
            last_owner <= OWN_IFU;
            addr_q     <= ifu_addr;
            wen_q      <= 1'b0;
            wdata_q    <= '0;
            wmask_q    <= '0;
        end else if (grant_lsu) begin
            owner      <= OWN_LSU;
            last_owner <= OWN_LSU;
            addr_q     <= lsu_addr;
            wen_q      <= lsu_wen;
            wdata_q    <= lsu_wdata;
            wmask_q    <= lsu_wmask;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wen   = wen_q;
    assign mem_wdata = wdata_q;
    assign mem_wmask = wmask_q;
    assign ifu_rdata = mem_rdata;
    assign lsu_rdata = mem_rdata;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model checked every cycle, plus directed scenarios.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = DW / 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ifu_req_valid = 1'b0;
    logic          ifu_req_ready;
    logic [AW-1:0] ifu_addr = '0;
    logic          ifu_rsp_valid;
    logic [DW-1:0] ifu_rdata;
    logic          lsu_req_valid = 1'b0;
    logic          lsu_req_ready;
    logic [AW-1:0] lsu_addr = '0;
    logic          lsu_wen = 1'b0;
    logic [DW-1:0] lsu_wdata = '0;
    logic [MW-1:0] lsu_wmask = '0;
    logic          lsu_rsp_valid;
    logic [DW-1:0] lsu_rdata;
    logic          mem_req_valid;
    logic          mem_req_ready = 1'b0;
    logic [AW-1:0] mem_addr;
    logic          mem_wen;
    logic [DW-1:0] mem_wdata;
    logic [MW-1:0] mem_wmask;
    logic          mem_rsp_valid;
    logic [DW-1:0] mem_rdata = '0;
    logic          busy;
    logic          rsp_drv = 1'b0;
    logic          inj = 1'b0;

    assign mem_rsp_valid = rsp_drv | inj;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Memory responder: stall_cfg cycles of ready low in ISSUE, lat_cfg extra cycles before response.
    int stall_cfg = 0;
    int lat_cfg = 0;
    int st_cnt = 0;
    int lat_cnt = 0;
    bit hs_seen = 0;
    bit waiting = 0;

    always @(negedge clk) hs_seen = mem_req_valid && mem_req_ready;

    always @(posedge clk) begin
        #1;
        rsp_drv = 1'b0;
        if (hs_seen) begin
            waiting = 1;
            lat_cnt = 0;
            hs_seen = 0;
        end
        if (waiting) begin
            if (lat_cnt >= lat_cfg) begin
                rsp_drv = 1'b1;
                waiting = 0;
            end else begin
                lat_cnt++;
            end
        end
        mem_req_ready = 1'b0;
        if (mem_req_valid) begin
            if (st_cnt >= stall_cfg) begin
                mem_req_ready = 1'b1;
                st_cnt = 0;
            end else begin
                st_cnt++;
            end
        end else begin
            st_cnt = 0;
        end
    end

    // Reference model: one pending transaction record (accepted / sent downstream) plus round-robin memory.
    bit            m_txn, m_sent, m_own, m_last;
    logic [AW-1:0] m_addr;
    logic          m_wen;
    logic [DW-1:0] m_wdata;
    logic [MW-1:0] m_wmask;
    bit            e_ir, e_lr, e_mv, e_irsp, e_lrsp;
    int            n_ifu_rsp = 0;
    int            n_lsu_rsp = 0;

    always @(negedge clk) begin
        if (rst) begin
            m_txn = 0; m_sent = 0; m_own = 0; m_last = 1;
            m_addr = '0; m_wen = 0; m_wdata = '0; m_wmask = '0;
        end
        e_ir   = !rst && !m_txn && ifu_req_valid && (!lsu_req_valid || m_last);
        e_lr   = !rst && !m_txn && lsu_req_valid && (!ifu_req_valid || !m_last);
        e_mv   = m_txn && !m_sent;
        e_irsp = m_txn && m_sent && mem_rsp_valid && !m_own;
        e_lrsp = m_txn && m_sent && mem_rsp_valid && m_own;
        chk("ifu_req_ready", ifu_req_ready, e_ir);
        chk("lsu_req_ready", lsu_req_ready, e_lr);
        chk("mem_req_valid", mem_req_valid, e_mv);
        chk("ifu_rsp_valid", ifu_rsp_valid, e_irsp);
        chk("lsu_rsp_valid", lsu_rsp_valid, e_lrsp);
        chk("busy", busy, m_txn);
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_wen", mem_wen, m_wen);
        chk("mem_wdata", mem_wdata, m_wdata);
        chk("mem_wmask", mem_wmask, m_wmask);
        chk("ifu_rdata", ifu_rdata, mem_rdata);
        chk("lsu_rdata", lsu_rdata, mem_rdata);
        if (ifu_rsp_valid) n_ifu_rsp++;
        if (lsu_rsp_valid) n_lsu_rsp++;
        if (!rst) begin
            if (e_irsp || e_lrsp) begin
                m_txn = 0;
            end else if (e_mv && mem_req_ready) begin
                m_sent = 1;
            end else if (e_ir) begin
                m_txn = 1; m_sent = 0; m_own = 0; m_last = 0;
                m_addr = ifu_addr; m_wen = 0; m_wdata = '0; m_wmask = '0;
            end else if (e_lr) begin
                m_txn = 1; m_sent = 0; m_own = 1; m_last = 1;
                m_addr = lsu_addr; m_wen = lsu_wen; m_wdata = lsu_wdata; m_wmask = lsu_wmask;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick(1);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    // Holds the IFU request until accepted; returns at the cycle after the handshake.
    task automatic ifu_go(input logic [AW-1:0] a, output int gc);
        ifu_req_valid = 1'b1;
        ifu_addr      = a;
        gc = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ifu_req_ready) begin
                gc = cyc;
                break;
            end
        end
        chk("ifu_grant_within_budget", gc >= 0, 1'b1);
        tick(1);
        ifu_req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("idle_within_budget", busy, 1'b0);
    endtask

    int c0, gc, rc, lg, g, mv_cnt, r0, i0;
    int ord[6];
    int gcy[6];

    initial begin
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0000;
        mem_rdata     = 32'h0010_0073;
        @(negedge clk);
        chk("reset_ifu_ready", ifu_req_ready, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_mem_req_valid", mem_req_valid, 1'b0);
        chk("reset_mem_addr", mem_addr, 32'h0);

        // IFU fetch, zero-wait memory
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        c0 = cyc;
        chk("t1_ifu_ready_c0", ifu_req_ready, 1'b1);
        chk("t1_lsu_ready_c0", lsu_req_ready, 1'b0);
        tick(1);
        ifu_req_valid = 1'b0;
        @(negedge clk);
        chk("t1_mem_req_valid_c1", mem_req_valid, 1'b1);
        chk("t1_mem_addr_c1", mem_addr, 32'h8000_0000);
        chk("t1_mem_wen_c1", mem_wen, 1'b0);
        @(negedge clk);
        chk("t1_ifu_rsp_c2", ifu_rsp_valid, 1'b1);
        chk("t1_ifu_rdata_c2", ifu_rdata, 32'h0010_0073);
        chk("t1_lsu_rsp_c2", lsu_rsp_valid, 1'b0);
        @(negedge clk);
        chk("t1_busy_c3", busy, 1'b0);
        chk("t1_latency", cyc - c0, 3);

        // LSU store
        mem_rdata = 32'h1234_5678;
        r0 = n_lsu_rsp;
        i0 = n_ifu_rsp;
        tick(1);
        lsu_req_valid = 1'b1;
        lsu_addr = 32'h8000_1000; lsu_wen = 1'b1; lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF;
        @(negedge clk);
        chk("t2_lsu_ready", lsu_req_ready, 1'b1);
        tick(1);
        lsu_req_valid = 1'b0;
        @(negedge clk);
        chk("t2_mem_wen", mem_wen, 1'b1);
        chk("t2_mem_addr", mem_addr, 32'h8000_1000);
        chk("t2_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("t2_mem_wmask", mem_wmask, 4'hF);
        @(negedge clk);
        chk("t2_lsu_rsp", lsu_rsp_valid, 1'b1);
        chk("t2_ifu_rsp", ifu_rsp_valid, 1'b0);
        tick(3);
        chk("t2_lsu_rsp_count", n_lsu_rsp - r0, 1);
        chk("t2_ifu_rsp_count", n_ifu_rsp - i0, 0);

        // Continuous contention after reset
        do_reset();
        r0 = n_lsu_rsp;
        i0 = n_ifu_rsp;
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0100;
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0200; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
        g = 0;
        for (int i = 0; i < 60 && g < 6; i++) begin
            @(negedge clk);
            if (ifu_req_ready) begin
                ord[g] = 0; gcy[g] = cyc; g++;
            end else if (lsu_req_ready) begin
                ord[g] = 1; gcy[g] = cyc; g++;
            end
        end
        tick(1);
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        chk("t3_grant_count", g, 6);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("t3_grant_owner_%0d", k), ord[k], k % 2);
            chk($sformatf("t3_grant_spacing_%0d", k), gcy[k] - gcy[0], 3 * k);
        end
        wait_idle();
        tick(2);
        chk("t3_ifu_rsp_count", n_ifu_rsp - i0, 3);
        chk("t3_lsu_rsp_count", n_lsu_rsp - r0, 3);

        // Stalled issue plus slow response, with LSU waiting behind
        stall_cfg = 4;
        lat_cfg   = 3;
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0040;
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_2000; lsu_wen = 1'b0;
        @(negedge clk);
        c0 = cyc;
        chk("t4_ifu_wins_tie", ifu_req_ready, 1'b1);
        tick(1);
        ifu_req_valid = 1'b0;
        rc = -1; lg = -1; mv_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (mem_req_valid) mv_cnt++;
            if (ifu_rsp_valid) rc = cyc;
            if (lsu_req_ready) begin
                lg = cyc;
                break;
            end
        end
        chk("t4_rsp_offset", rc - c0, 9);
        chk("t4_next_grant_offset", lg - c0, 10);
        chk("t4_issue_cycles", mv_cnt, 5);
        tick(1);
        lsu_req_valid = 1'b0;
        wait_idle();
        stall_cfg = 0;
        lat_cfg   = 0;

        // Spurious memory responses in IDLE and ISSUE
        tick(1);
        i0 = n_ifu_rsp;
        r0 = n_lsu_rsp;
        stall_cfg = 2;
        inj = 1'b1;
        @(negedge clk);
        chk("t5_idle_inj_ifu_rsp", ifu_rsp_valid, 1'b0);
        chk("t5_idle_inj_lsu_rsp", lsu_rsp_valid, 1'b0);
        chk("t5_idle_inj_busy", busy, 1'b0);
        tick(1);
        inj = 1'b0;
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0080;
        @(negedge clk);
        c0 = cyc;
        chk("t5_ifu_ready", ifu_req_ready, 1'b1);
        tick(1);
        ifu_req_valid = 1'b0;
        inj = 1'b1;
        @(negedge clk);
        chk("t5_issue_inj_mem_req_valid", mem_req_valid, 1'b1);
        chk("t5_issue_inj_ifu_rsp", ifu_rsp_valid, 1'b0);
        tick(1);
        inj = 1'b0;
        @(negedge clk);
        chk("t5_still_issuing", mem_req_valid, 1'b1);
        rc = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ifu_rsp_valid) begin
                rc = cyc;
                break;
            end
        end
        chk("t5_rsp_offset", rc - c0, 4);
        tick(2);
        chk("t5_ifu_rsp_count", n_ifu_rsp - i0, 1);
        chk("t5_lsu_rsp_count", n_lsu_rsp - r0, 0);
        stall_cfg = 0;

        // Reset while waiting for the response
        lat_cfg = 3;
        i0 = n_ifu_rsp;
        ifu_go(32'h8000_00C0, gc);
        @(negedge clk);
        chk("t6_issue", mem_req_valid, 1'b1);
        tick(1);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_mem_addr", mem_addr, 32'h0);
        chk("t6_rst_ifu_rsp", ifu_rsp_valid, 1'b0);
        tick(1);
        rst = 1'b0;
        tick(2);
        @(negedge clk);
        chk("t6_late_rsp_present", mem_rsp_valid, 1'b1);
        chk("t6_late_rsp_ignored", ifu_rsp_valid, 1'b0);
        chk("t6_late_rsp_busy", busy, 1'b0);
        lat_cfg = 0;
        tick(1);
        ifu_go(32'h8000_0100, gc);
        @(negedge clk);
        chk("t6_next_addr", mem_addr, 32'h8000_0100);
        @(negedge clk);
        chk("t6_next_rsp", ifu_rsp_valid, 1'b1);
        tick(2);
        chk("t6_ifu_rsp_count", n_ifu_rsp - i0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        n_err++;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

endmodule
